// File: rtl/bcd_cascade_scan.sv
// rtl/bcd_cascade_scan.sv - 4-digit BCD cascade of an upstream decade counter with multiplexed 7-segment scan (optional LEADING_ZERO_BLANK_EN)
module bcd_cascade_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cnt_in,
    input  logic        cin,
    output logic [15:0] bcd_val,
    output logic        ovf,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [3:0]    units;
    logic [3:0]    tens;
    logic [3:0]    hundreds;
    logic [3:0]    thousands;
    logic          cin_d;
    logic          inc;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    dig_idx;
    logic [3:0]    cur_digit;
    logic          blank;
    logic [7:0]    seg_next;

    assign inc     = cin & ~cin_d;
    assign bcd_val = {thousands, hundreds, tens, units};

    always_comb begin
        cur_digit = units;
        case (dig_idx)
            2'd0: cur_digit = units;
            2'd1: cur_digit = tens;
            2'd2: cur_digit = hundreds;
            2'd3: cur_digit = thousands;
            default: cur_digit = units;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks only when it and every more significant digit are zero.
    always_comb begin
        blank = 1'b0;
        case (dig_idx)
            2'd3: blank = (thousands == 4'd0);
            2'd2: blank = (thousands == 4'd0) && (hundreds == 4'd0);
            2'd1: blank = (thousands == 4'd0) && (hundreds == 4'd0) && (tens == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_next = 8'hFF;
        if (!blank) begin
            case (cur_digit)
                4'd0: seg_next = 8'hC0;
                4'd1: seg_next = 8'hF9;
                4'd2: seg_next = 8'hA4;
                4'd3: seg_next = 8'hB0;
                4'd4: seg_next = 8'h99;
                4'd5: seg_next = 8'h92;
                4'd6: seg_next = 8'h82;
                4'd7: seg_next = 8'hF8;
                4'd8: seg_next = 8'h80;
                4'd9: seg_next = 8'h90;
                default: seg_next = 8'hBF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            units     <= 4'd0;
            tens      <= 4'd0;
            hundreds  <= 4'd0;
            thousands <= 4'd0;
            cin_d     <= 1'b0;
            ovf       <= 1'b0;
            scan_cnt  <= '0;
            dig_idx   <= 2'd0;
            seg       <= 8'hFF;
            an        <= 4'b1111;
        end else begin
            units <= cnt_in;
            cin_d <= cin;
            ovf   <= 1'b0;
            // Ripple carry through the upper decades on a cin rising edge.
            if (inc) begin
                if (tens == 4'd9) begin
                    tens <= 4'd0;
                    if (hundreds == 4'd9) begin
                        hundreds <= 4'd0;
                        if (thousands == 4'd9) begin
                            thousands <= 4'd0;
                            ovf       <= 1'b1;
                        end else begin
                            thousands <= thousands + 4'd1;
                        end
                    end else begin
                        hundreds <= hundreds + 4'd1;
                    end
                end else begin
                    tens <= tens + 4'd1;
                end
            end

            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                dig_idx  <= dig_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            an  <= ~(4'b0001 << dig_idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_cascade_scan.sv
// tb/tb_bcd_cascade_scan.sv - scoreboard bench for bcd_cascade_scan against an integer count model
module tb_bcd_cascade_scan;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cnt_in = 4'd0;
    logic        cin = 1'b0;
    logic [15:0] bcd_val;
    logic        ovf;
    logic [7:0]  seg;
    logic [3:0]  an;

    bcd_cascade_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .cnt_in  (cnt_in),
        .cin     (cin),
        .bcd_val (bcd_val),
        .ovf     (ovf),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [7:0]  seg;
        logic [3:0]  an;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: upper = tens..thousands as one integer 0..999.
    int   m_upper = 0;
    int   m_units = 0;
    bit   m_cin_prev = 1'b0;
    int   m_cyc = 0;
    logic [7:0] m_seg = 8'hFF;
    logic [3:0] m_an  = 4'hF;

    function automatic logic [7:0] decode(input int v);
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    task automatic model_step(input bit r, input int c, input bit ci);
        exp_t e;
        int   idx;
        int   dval;
        bit   blank;
        bit   o;
        o = 1'b0;
        if (r) begin
            m_upper = 0; m_units = 0; m_cin_prev = 1'b0; m_cyc = 0;
            m_seg = 8'hFF; m_an = 4'hF;
        end else begin
            idx   = (m_cyc / SCAN_DIV) % 4;
            dval  = (idx == 0) ? m_units : (idx == 1) ? m_upper % 10 :
                    (idx == 2) ? (m_upper / 10) % 10 : m_upper / 100;
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (idx == 3 && m_upper < 100) || (idx == 2 && m_upper < 10) ||
                    (idx == 1 && m_upper == 0);
`endif
            m_seg = blank ? 8'hFF : decode(dval);
            m_an  = ~(4'b0001 << idx);
            m_cyc++;
            if (ci && !m_cin_prev) begin
                o = (m_upper == 999);
                m_upper = (m_upper + 1) % 1000;
            end
            m_units    = c;
            m_cin_prev = ci;
        end
        e.bcd = {4'(m_upper / 100), 4'((m_upper / 10) % 10), 4'(m_upper % 10), 4'(m_units)};
        e.ovf = o;
        e.seg = m_seg;
        e.an  = m_an;
        q.push_back(e);
    endtask

    task automatic drive(input bit r, input int c, input bit ci);
        @(negedge clk);
        rst    = r;
        cnt_in = 4'(c);
        cin    = ci;
        model_step(r, c, ci);
    endtask

    task automatic pulses(input int n, input int c);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, (c < 0) ? int'($urandom_range(0, 9)) : c, 1'b1);
            drive(1'b0, (c < 0) ? int'($urandom_range(0, 9)) : c, 1'b0);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("bcd_val", 32'(bcd_val), 32'(e.bcd));
            check("ovf",     32'(ovf),     32'(e.ovf));
            check("seg",     32'(seg),     32'(e.seg));
            check("an",      32'(an),      32'(e.an));
        end
    end

    initial begin
        int wait_cnt;
        repeat (3) drive(1'b1, 0, 1'b0);
        repeat (20) drive(1'b0, 7, 1'b0);
        // Held carry counts once, then a second edge.
        repeat (5) drive(1'b0, 7, 1'b1);
        repeat (3) drive(1'b0, 7, 1'b0);
        drive(1'b0, 7, 1'b1);
        repeat (2) drive(1'b0, 7, 1'b0);
        // 002 -> 099, then ripple to 100.
        pulses(97, -1);
        repeat (4) drive(1'b0, 3, 1'b0);
        pulses(1, 3);
        repeat (4) drive(1'b0, 3, 1'b0);
        // 100 -> 999, then wrap with ovf.
        pulses(899, -1);
        repeat (4) drive(1'b0, 0, 1'b0);
        pulses(1, 2);
        repeat (6) drive(1'b0, 2, 1'b0);
        repeat (16) drive(1'b0, 12, 1'b0);
        // Build 0345 and reset mid-scan on digit 2.
        drive(1'b1, 0, 1'b0);
        pulses(34, 5);
        wait_cnt = 0;
        while ((((m_cyc / SCAN_DIV) % 4) != 2 || (m_cyc % SCAN_DIV) != 1) && wait_cnt < 64) begin
            drive(1'b0, 5, 1'b0);
            wait_cnt++;
        end
        drive(1'b1, 5, 1'b0);
        repeat (10) drive(1'b0, 5, 1'b0);
        // 0045 shows leading-zero behaviour on digits 2 and 3.
        drive(1'b1, 0, 1'b0);
        pulses(4, 5);
        repeat (20) drive(1'b0, 5, 1'b0);
        for (int i = 0; i < 800; i++)
            drive(($urandom_range(0, 99) == 0), int'($urandom_range(0, 15)), $urandom_range(0, 1));

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
